// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, strobe patterns
// and the access legality check.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // True when the access must be rejected before reaching memory.
    function automatic logic access_fault(input logic wen, input logic [2:0] funct3,
                                          input logic [1:0] addr);
        logic illegal;
        logic misaligned;
        if (wen)
            illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
        else
            illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data lane select with sign/zero extension for RV32I loads.
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{(DATA_W-8){byte_v[7]}}, byte_v};
            F3_LH:   data = {{(DATA_W-16){half_v[15]}}, half_v};
            F3_LW:   data = rdata;
            F3_LBU:  data = {{(DATA_W-8){1'b0}}, byte_v};
            F3_LHU:  data = {{(DATA_W-16){1'b0}}, half_v};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit: accepts one operation at a time, checks alignment and
// legality, runs a valid/ready handshake with data memory and returns extended load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp_err
);

    lsu_state_e        state, state_next;
    logic              wen_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              fault;
    logic [3:0]        strb_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] ext_data;

    lsu_load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .rdata  (mem_rdata),
        .addr   (off_q),
        .funct3 (funct3_q),
        .data   (ext_data)
    );

    // Store lane strobes and replicated data, formed from the incoming request.
    always_comb begin
        fault   = access_fault(req_wen, req_funct3, req_addr[1:0]);
        strb_c  = '0;
        wdata_c = req_wdata;
        if (req_wen) begin
            case (req_funct3)
                F3_SB: begin
                    strb_c  = STRB_B << req_addr[1:0];
                    wdata_c = {4{req_wdata[7:0]}};
                end
                F3_SH: begin
                    strb_c  = STRB_H << {req_addr[1], 1'b0};
                    wdata_c = {2{req_wdata[15:0]}};
                end
                F3_SW:   strb_c = STRB_W;
                default: strb_c = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = fault ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = ST_WAIT;
            end
            ST_WAIT: if (mem_resp_valid) state_next = ST_DONE;
            ST_DONE: begin
                resp_valid = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        mem_wen   = mem_req_valid & wen_q;
        mem_wstrb = mem_req_valid ? wstrb_q : '0;
    end

    // Response registers only change on entry to DONE so they hold between operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q    <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    wen_q    <= req_wen;
                    funct3_q <= req_funct3;
                    off_q    <= req_addr[1:0];
                    addr_q   <= {req_addr[ADDR_W-1:2], 2'b00};
                    wdata_q  <= wdata_c;
                    wstrb_q  <= strb_c;
                    if (fault) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                ST_WAIT: if (mem_resp_valid) begin
                    rdata_q <= (wen_q || mem_resp_err) ? '0 : ext_data;
                    err_q   <= mem_resp_err;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
